preg_free_list: RTL
===================

# preg_free_list

Physical-register free-list controller for the rename stage. Hands out up to two free physical tags per cycle to the two rename lanes and accepts up to two released tags per cycle from retire. Replaces the bit-vector scan with a circular FIFO of tags. Grants are all-or-nothing and in order; the block raises a stall when the pool cannot cover the cycle's requests.

## Interface
Parameters:
- NUM_PREGS, 64, physical register count
- NUM_AREGS, 32, architectural register count; tags 0..NUM_AREGS-1 are mapped at reset
- TAG_W, 6, tag width, equals clog2(NUM_PREGS)
- DEPTH, NUM_PREGS-NUM_AREGS (32), FIFO capacity

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- alloc_req_1  in  1  lane 1 needs a destination tag (writes rd, rd != x0)
- alloc_req_2  in  1  lane 2 needs a destination tag (younger than lane 1)
- alloc_gnt  out  1  all asserted requests granted this cycle
- alloc_tag_1  out  TAG_W  tag for lane 1
- alloc_tag_2  out  TAG_W  tag for lane 2
- stall  out  1  a request exists and alloc_gnt is 0
- free_vld_1, free_vld_2  in  1 each  retire releases a tag
- free_tag_1, free_tag_2  in  TAG_W each  released tag (previous mapping of rd)
- free_count  out  clog2(DEPTH)+1 (6)  tags currently held
- err_overflow  out  1  sticky: a push arrived with FIFO full

## Operation
- Storage: DEPTH entries of TAG_W, head pointer, tail pointer (clog2(DEPTH) bits, wrap modulo DEPTH), count register.
- Reset: entry[i] = NUM_AREGS+i, head = 0, tail = 0, count = DEPTH, err_overflow = 0.
- Request count n = alloc_req_1 + alloc_req_2.
- alloc_gnt = (n <= count). With n = 0, alloc_gnt = 1 and nothing pops.
- Tag steering: when alloc_req_1, alloc_tag_1 = entry[head] and alloc_tag_2 = entry[head+1]. When only alloc_req_2, alloc_tag_2 = entry[head]. Unrequested tag outputs are don't-care but deterministic, driving entry[head] / entry[head+1].
- On a granted edge: head += n, count -= n.
- Frees: valid tags with tag == 0 are dropped; x0 is never recycled.
  - Push order is free_1 then free_2 at tail, tail += pushes.
  - Pushes beyond capacity, evaluated after this cycle's pops, are dropped and set err_overflow.
- Next count = count - (granted pops) + (accepted pushes).
- No bypass: tags freed in cycle t become allocatable in cycle t+1.
- A denied cycle pops nothing; lane 1 is never granted without lane 2 when both request.

## Timing
- alloc_gnt, alloc_tag_*, and stall are combinational from registered state and alloc_req_*. Zero-cycle allocate latency; rename samples them on the same edge.
- free_* inputs are sampled on the rising edge. One-cycle free-to-available latency.
- free_count and err_overflow are registered.
- Reset mid-operation: all state returns to reset values immediately; outstanding tags are forgotten (the rename RAT resets with it).
- Boundaries:
  - count = 1 with n = 2: stall, even if frees arrive this edge.
  - count = 0: any request stalls.
  - Pointer wrap from DEPTH-1 to 0 is seamless, including a dual pop or push straddling the wrap.

## Structure
- Shared package: NUM_PREGS, NUM_AREGS, TAG_W, and the typedef preg_tag_t, shared with rename and retire.
- One natural sub-module, `circ_buf_2r2w`: a circular buffer with two reads at head/head+1 and two writes at tail/tail+1. It carries pointers, count, and overflow detection. The top holds the grant logic, the x0 filter, and push compaction (free_2 goes to slot 0 when free_1 is absent).

## Test plan
- Reset -> alloc_tag_1 = 32, alloc_tag_2 = 33, free_count = 32, stall = 0, err_overflow = 0.
- Both requests held for 16 cycles -> tags 32/33, 34/35 … 62/63. free_count = 0 after. The 17th cycle gives alloc_gnt = 0 and stall = 1.
- count = 0 plus free_tag_1 = 40 and free_tag_2 = 7 with requests held -> stall in that cycle. Next cycle alloc_gnt = 1 with tags 40 and 7, then free_count = 0.
- Only alloc_req_2 at reset -> alloc_tag_2 = 32; next cycle alloc_tag_1 = 33, free_count = 31.
- free_vld_1 with tag 0 at count 31 -> ignored, count stays 31. Two frees of 5 and 9 at count 31 -> 5 accepted, 9 dropped, err_overflow = 1 and stays set until reset.
- Pointers parked at 31: a dual alloc and dual free in the same cycle -> head = 1, tail = 1, count unchanged, tags read from entries 31 and 0.

Source files
------------

// File: rtl/preg_free_list_pkg.sv
// Shared sizing and tag type for the physical-register free list, rename and retire.
// Also holds a small modulo-add helper used for the circular-buffer pointers.
package preg_free_list_pkg;

    localparam int NUM_PREGS = 64;
    localparam int NUM_AREGS = 32;
    localparam int TAG_W     = $clog2(NUM_PREGS);
    localparam int DEPTH     = NUM_PREGS - NUM_AREGS;
    localparam int PTR_W     = $clog2(DEPTH);
    localparam int CNT_W     = PTR_W + 1;

    typedef logic [TAG_W-1:0] preg_tag_t;

    function automatic logic [1:0] bit_sum2(input logic a, input logic b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    // Advance a pointer by k (k < depth) with wrap modulo depth.
    function automatic int wrap_add(input int p, input int k, input int depth);
        int s;
        s = p + k;
        return (s >= depth) ? (s - depth) : s;
    endfunction

endpackage

// File: rtl/preg_free_list_circ_buf_2r2w.sv
// Circular tag buffer with two reads at head/head+1 and two writes at tail/tail+1.
// Pops are trusted by the caller; pushes that exceed capacity after pops are dropped.
module circ_buf_2r2w
    import preg_free_list_pkg::*;
#(
    parameter int N_ENTRIES  = 32,
    parameter int ENTRY_W    = 6,
    parameter int RESET_BASE = 32
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [1:0]                          pop_n_i,
    input  logic [1:0]                          push_n_i,
    input  logic [ENTRY_W-1:0]                  push_tag_0_i,
    input  logic [ENTRY_W-1:0]                  push_tag_1_i,
    output logic [ENTRY_W-1:0]                  rd_tag_0_o,
    output logic [ENTRY_W-1:0]                  rd_tag_1_o,
    output logic [$clog2(N_ENTRIES):0]          count_o,
    output logic                                overflow_o
);

    localparam int IDX_W = $clog2(N_ENTRIES);
    localparam int OCC_W = IDX_W + 1;

    logic [ENTRY_W-1:0] mem_q [N_ENTRIES];
    logic [IDX_W-1:0]   head_q, head_d, tail_q, tail_d;
    logic [IDX_W-1:0]   head_nx, tail_nx;
    logic [OCC_W-1:0]   count_q, count_d, occ_after_pop, space;
    logic [1:0]         push_acc;
    logic               ovf_d, overflow_q;

    assign head_nx = IDX_W'(wrap_add(int'(head_q), 1, N_ENTRIES));
    assign tail_nx = IDX_W'(wrap_add(int'(tail_q), 1, N_ENTRIES));

    assign rd_tag_0_o = mem_q[head_q];
    assign rd_tag_1_o = mem_q[head_nx];
    assign count_o    = count_q;
    assign overflow_o = overflow_q;

    // Capacity is judged after this cycle's pops, so a full buffer that pops two can take two.
    always_comb begin
        occ_after_pop = count_q - OCC_W'(pop_n_i);
        space         = OCC_W'(N_ENTRIES) - occ_after_pop;
        push_acc      = push_n_i;
        ovf_d         = 1'b0;
        if (OCC_W'(push_n_i) > space) begin
            push_acc = space[1:0];
            ovf_d    = 1'b1;
        end
        head_d  = IDX_W'(wrap_add(int'(head_q), int'(pop_n_i), N_ENTRIES));
        tail_d  = IDX_W'(wrap_add(int'(tail_q), int'(push_acc), N_ENTRIES));
        count_d = occ_after_pop + OCC_W'(push_acc);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= OCC_W'(N_ENTRIES);
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_q | ovf_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                mem_q[i] <= ENTRY_W'(RESET_BASE + i);
            end
        end else begin
            if (push_acc != 2'd0) begin
                mem_q[tail_q] <= push_tag_0_i;
            end
            if (push_acc == 2'd2) begin
                mem_q[tail_nx] <= push_tag_1_i;
            end
        end
    end

endmodule

// File: rtl/preg_free_list.sv
// Rename-stage free list: all-or-nothing dual tag grant from a circular FIFO,
// dual release from retire with x0 filtering and push compaction.
module preg_free_list
    import preg_free_list_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alloc_req_1,
    input  logic             alloc_req_2,
    output logic             alloc_gnt,
    output logic [TAG_W-1:0] alloc_tag_1,
    output logic [TAG_W-1:0] alloc_tag_2,
    output logic             stall,
    input  logic             free_vld_1,
    input  logic             free_vld_2,
    input  logic [TAG_W-1:0] free_tag_1,
    input  logic [TAG_W-1:0] free_tag_2,
    output logic [CNT_W-1:0] free_count,
    output logic             err_overflow
);

    logic [1:0]       req_n, pop_n, push_n;
    logic [CNT_W-1:0] count;
    logic             keep_1, keep_2;
    preg_tag_t        head_tag, next_tag, push_tag_0;

    assign req_n     = bit_sum2(alloc_req_1, alloc_req_2);
    assign alloc_gnt = (CNT_W'(req_n) <= count);
    assign stall     = (req_n != 2'd0) && !alloc_gnt;
    assign pop_n     = alloc_gnt ? req_n : 2'd0;

    // A lone lane-2 request takes the head tag; otherwise lane 2 gets head+1.
    assign alloc_tag_1 = head_tag;
    assign alloc_tag_2 = (alloc_req_2 && !alloc_req_1) ? head_tag : next_tag;

    assign keep_1     = free_vld_1 && (free_tag_1 != '0);
    assign keep_2     = free_vld_2 && (free_tag_2 != '0);
    assign push_n     = bit_sum2(keep_1, keep_2);
    assign push_tag_0 = keep_1 ? free_tag_1 : free_tag_2;

    circ_buf_2r2w #(
        .N_ENTRIES  (DEPTH),
        .ENTRY_W    (TAG_W),
        .RESET_BASE (NUM_AREGS)
    ) u_buf (
        .clk          (clk),
        .rst_n        (rst_n),
        .pop_n_i      (pop_n),
        .push_n_i     (push_n),
        .push_tag_0_i (push_tag_0),
        .push_tag_1_i (free_tag_2),
        .rd_tag_0_o   (head_tag),
        .rd_tag_1_o   (next_tag),
        .count_o      (count),
        .overflow_o   (err_overflow)
    );

    assign free_count = count;

endmodule
